// File: rtl/proc_pkg.sv
// Shared definitions for the 2602 control path: opcodes, register codes, sequencer states, ALU ops.
// CTRL_ILLEGAL_HALT_EN adds the HALT state used to trap illegal opcodes.
package proc_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [2:0] regcode_t;

  localparam opcode_t OP_LOAD = 4'b0000;
  localparam opcode_t OP_MOVE = 4'b0001;
  localparam opcode_t OP_ADD  = 4'b0010;
  localparam opcode_t OP_XOR  = 4'b0011;
  localparam opcode_t OP_BR   = 4'b1000;

  localparam regcode_t REG_NA = 3'd0;
  localparam regcode_t REG_R1 = 3'd1;
  localparam regcode_t REG_R2 = 3'd2;
  localparam regcode_t REG_R3 = 3'd3;
  localparam regcode_t REG_R4 = 3'd4;
  localparam regcode_t REG_R5 = 3'd5;
  localparam regcode_t REG_R6 = 3'd6;
  localparam regcode_t REG_PC = 3'd7;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_XOR = 1'b1;

  typedef enum logic [2:0] {
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3
`ifdef CTRL_ILLEGAL_HALT_EN
    , ST_HALT
`endif
  } state_t;

  function automatic logic is_legal(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_MOVE) || (op == OP_ADD) ||
           (op == OP_XOR) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register code to one-hot strobe decoder; the NA (lowest) and PC (highest) codes never produce a strobe.
module reg_sel_decoder #(
  parameter int ARG_SIZE = 3
) (
  input  logic                     en,
  input  logic [ARG_SIZE-1:0]      code,
  output logic [(1<<ARG_SIZE)-1:0] onehot
);

  localparam int N = 1 << ARG_SIZE;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    if (gi == 0 || gi == N - 1) begin : g_masked
      assign onehot[gi] = 1'b0;
    end else begin : g_live
      assign onehot[gi] = en && (code == ARG_SIZE'(gi));
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: latches an instruction in T0, runs 1-3 execute steps, pulses done/branch.
// Define CTRL_ILLEGAL_HALT_EN to trap illegal opcodes in HALT instead of treating them as NOPs.
module control_unit
  import proc_pkg::*;
#(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              run,
  input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0] instruction,
  output logic                              done,
  output logic                              branch,
  output logic [ARG_NUM*ARG_SIZE-1:0]       branchaddress,
  output logic [(1<<ARG_SIZE)-1:0]          rin,
  output logic [(1<<ARG_SIZE)-1:0]          rout,
  output logic                              din_out,
  output logic                              a_in,
  output logic                              g_in,
  output logic                              g_out,
  output logic                              alu_op,
  output logic                              illegal
);

  localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;

  state_t                state_reg;
  logic [IW-1:0]         ir_reg;

  logic [OP_SIZE-1:0]    opcode;
  logic [ARG_SIZE-1:0]   arg1;
  logic [ARG_SIZE-1:0]   arg2;

  assign opcode = ir_reg[IW-1 -: OP_SIZE];
  assign arg1   = ir_reg[2*ARG_SIZE-1 -: ARG_SIZE];
  assign arg2   = ir_reg[ARG_SIZE-1:0];

  // IR only loads on a fetch, so it stays frozen for the whole execute sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_T0;
      ir_reg    <= '0;
    end else begin
      case (state_reg)
        ST_T0: begin
          if (run) begin
            ir_reg    <= instruction;
            state_reg <= ST_T1;
          end
        end
        ST_T1: begin
          if (opcode == OP_ADD || opcode == OP_XOR) begin
            state_reg <= ST_T2;
`ifdef CTRL_ILLEGAL_HALT_EN
          end else if (!is_legal(opcode)) begin
            state_reg <= ST_HALT;
`endif
          end else begin
            state_reg <= ST_T0;
          end
        end
        ST_T2: state_reg <= ST_T3;
        ST_T3: state_reg <= ST_T0;
`ifdef CTRL_ILLEGAL_HALT_EN
        ST_HALT: state_reg <= ST_HALT;
`endif
        default: state_reg <= ST_T0;
      endcase
    end
  end

  logic                rin_en;
  logic                rout_en;
  logic [ARG_SIZE-1:0] rin_code;
  logic [ARG_SIZE-1:0] rout_code;

  always_comb begin
    done          = 1'b0;
    branch        = 1'b0;
    branchaddress = '0;
    din_out       = 1'b0;
    a_in          = 1'b0;
    g_in          = 1'b0;
    g_out         = 1'b0;
    alu_op        = ALU_ADD;
    illegal       = 1'b0;
    rin_en        = 1'b0;
    rout_en       = 1'b0;
    rin_code      = arg1;
    rout_code     = arg2;
    case (state_reg)
      ST_T1: begin
        case (opcode)
          OP_LOAD: begin
            din_out = 1'b1;
            rin_en  = 1'b1;
            done    = 1'b1;
          end
          OP_MOVE: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            done    = 1'b1;
          end
          OP_ADD, OP_XOR: begin
            rout_en   = 1'b1;
            rout_code = arg1;
            a_in      = 1'b1;
          end
          OP_BR: begin
            branch        = 1'b1;
            branchaddress = {arg1, arg2};
          end
          default: begin
            illegal = 1'b1;
`ifndef CTRL_ILLEGAL_HALT_EN
            done    = 1'b1;
`endif
          end
        endcase
      end
      ST_T2: begin
        rout_en = 1'b1;
        g_in    = 1'b1;
        alu_op  = (opcode == OP_XOR) ? ALU_XOR : ALU_ADD;
      end
      ST_T3: begin
        g_out  = 1'b1;
        rin_en = 1'b1;
        done   = 1'b1;
      end
`ifdef CTRL_ILLEGAL_HALT_EN
      ST_HALT: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  reg_sel_decoder #(.ARG_SIZE(ARG_SIZE)) u_rin_dec (
    .en     (rin_en),
    .code   (rin_code),
    .onehot (rin)
  );

  reg_sel_decoder #(.ARG_SIZE(ARG_SIZE)) u_rout_dec (
    .en     (rout_en),
    .code   (rout_code),
    .onehot (rout)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; honours CTRL_ILLEGAL_HALT_EN for the illegal-opcode scenario.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [9:0] instruction;
  logic       done, branch, din_out, a_in, g_in, g_out, alu_op, illegal;
  logic [5:0] branchaddress;
  logic [7:0] rin, rout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .instruction   (instruction),
    .done          (done),
    .branch        (branch),
    .branchaddress (branchaddress),
    .rin           (rin),
    .rout          (rout),
    .din_out       (din_out),
    .a_in          (a_in),
    .g_in          (g_in),
    .g_out         (g_out),
    .alu_op        (alu_op),
    .illegal       (illegal)
  );

  // Packed view: {done,branch,branchaddress[5:0],rin[7:0],rout[7:0],din_out,a_in,g_in,g_out,alu_op,illegal}
  logic [29:0] outs;
  assign outs = {done, branch, branchaddress, rin, rout, din_out, a_in, g_in, g_out, alu_op, illegal};

  function automatic logic [29:0] mk(input logic d, input logic b, input logic [5:0] ba,
                                     input logic [7:0] ri, input logic [7:0] ro,
                                     input logic di, input logic ai, input logic gin,
                                     input logic go, input logic ao, input logic il);
    return {d, b, ba, ri, ro, di, ai, gin, go, ao, il};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; instruction = 10'h008;
    step();
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL reset_hold: outs=%h expected=%h", outs, 30'h0);
    end
    rst = 1'b0; run = 1'b0;
    step();
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL reset_idle: outs=%h expected=%h", outs, 30'h0);
    end
    $display("reset: outs=%h", outs);
  endtask

  task automatic test_load();
    logic [29:0] exp;
    run = 1'b1; instruction = 10'h008;
    step();
    run = 1'b0; instruction = 10'h3FF;
    exp = mk(1, 0, 6'h00, 8'h02, 8'h00, 1, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL load_t1: outs=%h expected=%h", outs, exp);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== 30'h0) begin
        errors++;
        $display("FAIL load_t0_%0d: outs=%h expected=%h", i, outs, 30'h0);
      end
    end
    $display("load R1: done");
  endtask

  task automatic test_move();
    logic [29:0] exp;
    run = 1'b1; instruction = 10'h05A;
    step();
    run = 1'b0;
    exp = mk(1, 0, 6'h00, 8'h08, 8'h04, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL move_t1: outs=%h expected=%h", outs, exp);
    end
    step();
    $display("move R3,R2: done");
  endtask

  task automatic test_add();
    logic [29:0] exp_tab [4];
    exp_tab[0] = mk(0, 0, 6'h00, 8'h00, 8'h02, 0, 1, 0, 0, 0, 0);
    exp_tab[1] = mk(0, 0, 6'h00, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0);
    exp_tab[2] = mk(1, 0, 6'h00, 8'h02, 8'h00, 0, 0, 0, 1, 0, 0);
    exp_tab[3] = 30'h0;
    run = 1'b1; instruction = 10'h08A;
    step();
    // run dropped and instruction scrambled mid-execution must not disturb the sequence
    run = 1'b0; instruction = 10'h0FF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs !== exp_tab[i]) begin
        errors++;
        $display("FAIL add_step%0d: outs=%h expected=%h", i + 1, outs, exp_tab[i]);
      end
      step();
    end
    $display("add R1,R2: done");
  endtask

  task automatic test_xor_masked();
    logic [29:0] exp_tab [3];
    exp_tab[0] = mk(0, 0, 6'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0);
    exp_tab[1] = mk(0, 0, 6'h00, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0);
    exp_tab[2] = mk(1, 0, 6'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0);
    run = 1'b1; instruction = 10'h0C7;
    step();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs !== exp_tab[i]) begin
        errors++;
        $display("FAIL xor_step%0d: outs=%h expected=%h", i + 1, outs, exp_tab[i]);
      end
      step();
    end
    $display("xor R0,R7: done");
  endtask

  task automatic test_branch();
    logic [29:0] exp;
    run = 1'b1; instruction = 10'h22A;
    step();
    run = 1'b0;
    exp = mk(0, 1, 6'h2A, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL br_t1: outs=%h expected=%h", outs, exp);
    end
    step();
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL br_t0: outs=%h expected=%h", outs, 30'h0);
    end
    $display("br 0x2A: done");
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp_t1;
    int          pulses;
    exp_t1 = mk(1, 0, 6'h00, 8'h04, 8'h00, 1, 0, 0, 0, 0, 0);
    pulses = 0;
    run = 1'b1; instruction = 10'h010;
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(done);
      checks++;
      if (outs !== ((i % 2 == 0) ? exp_t1 : 30'h0)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: outs=%h expected=%h", i, outs,
                 (i % 2 == 0) ? exp_t1 : 30'h0);
      end
    end
    run = 1'b0;
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_rate: done_pulses=%0d expected=%0d", pulses, 3);
    end
    step();
    $display("back-to-back load R2: %0d completions in 6 cycles", pulses);
  endtask

  task automatic test_reset_mid_add();
    logic [29:0] exp;
    int          done_seen;
    done_seen = 0;
    run = 1'b1; instruction = 10'h08A;
    step();
    run = 1'b0;
    step();
    exp = mk(0, 0, 6'h00, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL rstmid_t2: outs=%h expected=%h", outs, exp);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL rstmid_abort: outs=%h expected=%h", outs, 30'h0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      done_seen += int'(done | branch);
    end
    checks++;
    if (done_seen !== 0 || outs !== 30'h0) begin
      errors++;
      $display("FAIL rstmid_idle: pulses=%0d outs=%h expected pulses=0 outs=%h",
               done_seen, outs, 30'h0);
    end
    $display("reset during add T2: abandoned");
  endtask

  task automatic test_illegal();
    logic [29:0] exp;
    run = 1'b1; instruction = 10'h140;
    step();
`ifdef CTRL_ILLEGAL_HALT_EN
    exp = mk(0, 0, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL halt_cycle%0d: outs=%h expected=%h", i, outs, exp);
      end
      step();
    end
    run = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL halt_release: outs=%h expected=%h", outs, 30'h0);
    end
    $display("illegal 0101: halted until reset");
`else
    run = 1'b0;
    exp = mk(1, 0, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL illegal_t1: outs=%h expected=%h", outs, exp);
    end
    step();
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL illegal_t0: outs=%h expected=%h", outs, 30'h0);
    end
    $display("illegal 0101: executed as NOP");
`endif
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instruction = '0;
    step();
    test_reset();
    test_load();
    test_move();
    test_add();
    test_xor_masked();
    test_branch();
    test_back_to_back();
    test_reset_mid_add();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction sequencer for the 2602 processor datapath. It sits directly downstream of the instruction ROM/PC stage: it latches the 10-bit instruction word presented by that stage and decodes it. It then drives register, accumulator and ALU control strobes over one to three execute steps. On completion it returns `done` (advance PC), or `branch` with `branchaddress` (load PC).

## Interface
- `OP_SIZE`, 4, opcode field width (instruction bits [9:6])
- `ARG_SIZE`, 3, register-field width (arg1 = bits [5:3], arg2 = bits [2:0])
- `ARG_NUM`, 2, number of argument fields; instruction width = `OP_SIZE + ARG_NUM*ARG_SIZE` = 10
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `run`  in  1  permits fetch of a new instruction in state T0
- `instruction`  in  10  current word from PC/ROM stage, valid whenever `done`/`branch` were not asserted on the previous edge
- `done`  out  1  one-cycle pulse: instruction complete, upstream PC increments
- `branch`  out  1  one-cycle pulse: upstream PC loads `branchaddress`
- `branchaddress`  out  6  branch target = {arg1, arg2}
- `rin`  out  8  one-hot register write enable, bit n = register code n
- `rout`  out  8  one-hot register-to-bus select
- `din_out`  out  1  external data onto bus
- `a_in`  out  1  load accumulator A from bus
- `g_in`  out  1  load G from ALU
- `g_out`  out  1  G onto bus
- `alu_op`  out  1  0 = add, 1 = xor
- `illegal`  out  1  unknown opcode indicator

## Operation
- Opcodes: LOAD 0000, MOVE 0001, ADD 0010, XOR 0011, BR 1000; all others illegal.
- Register codes: 000 = NA and 111 = PC are never written or read. `rin`/`rout` bits 0 and 7 are forced 0 and the step still advances.
- States: T0 (fetch), T1, T2, T3, and HALT (macro only).
- T0: all strobes 0.
  - `run`=1: latch `instruction` into IR, go to T1.
  - `run`=0: stay in T0.
- LOAD Rx: T1: `din_out`, `rin[x]`, `done` -> T0.
- MOVE Rx,Ry: T1: `rout[y]`, `rin[x]`, `done` -> T0.
- ADD/XOR Rx,Ry:
  - T1: `rout[x]`, `a_in`.
  - T2: `rout[y]`, `g_in`, `alu_op` (0 for ADD, 1 for XOR).
  - T3: `g_out`, `rin[x]`, `done` -> T0.
- BR: T1: `branch`=1, `done`=0, `branchaddress`={arg1,arg2} -> T0. Upstream gives `branch` priority over `done`.
- Illegal opcode, default build: T1: `done`=1, `illegal`=1 for that cycle, no other strobes -> T0 (NOP).
- `run` is sampled only in T0. Deasserting `run` mid-instruction does not abort the instruction.
- IR is held constant from T1 to the return to T0. `instruction` changes during execution are ignored.
- `branchaddress` is 0 outside the BR T1 cycle.

## Timing
- All outputs are combinational decodes of registered state + IR. There is no input-to-output combinational path.
- Reset: state = T0, IR = 0, all outputs 0 on the cycle after the `rst` edge.
- Reset mid-instruction abandons it with no `done`/`branch` pulse.
- Latency from the fetch edge to the completion pulse:
  - 1 cycle: LOAD, MOVE, BR, illegal.
  - 3 cycles: ADD, XOR.
- Completion always returns to T0. The next fetch occurs 1 cycle after completion, by which time the upstream PC has updated.
- Back-to-back LOAD with `run` held: issue rate of one instruction per 2 cycles.

## Configuration
- `CTRL_ILLEGAL_HALT_EN` defined:
  - An illegal opcode enters HALT.
  - `illegal` is held at 1 and no `done` or `branch` is issued.
  - The block stays in HALT until `rst`; `run` is ignored.
- `CTRL_ILLEGAL_HALT_EN` undefined: illegal opcode executes as a NOP as in Operation. HALT does not exist.

## Structure
- Shared package `proc_pkg`:
  - opcode constants;
  - register codes NA, R1–R6, PC;
  - state enum;
  - ALU op constants (add/xor).
- Sub-module `reg_sel_decoder`: 3-bit register code to 8-bit one-hot, bits 0 and 7 masked, with an enable input. Instantiated twice, for `rin` and `rout`.

## Test plan
- Reset, then `run`=1, instruction 0x008 (LOAD R1):
  - T1 shows `din_out`=1, `rin`=0x02, `done`=1;
  - next cycle T0 with all strobes 0.
- Instruction 0x08A (ADD R1,R2):
  - T1 `rout`=0x02 with `a_in`;
  - T2 `rout`=0x04 with `g_in`, `alu_op`=0;
  - T3 `g_out`, `rin`=0x02, `done`.
- Instruction 0x22A (BR 0x2A): T1 `branch`=1, `branchaddress`=0x2A, `done`=0.
- Instruction 0x0C7 (XOR R0,R7): T1/T3 `rin`=`rout`=0; T2 `alu_op`=1; `done` on T3.
- Opcode 0101: without the macro, `done`=1 with `illegal`=1 for one cycle. With `CTRL_ILLEGAL_HALT_EN`, `illegal` stays 1 and `done` never asserts until `rst`.
- `rst` asserted in T2 of an ADD: next cycle T0, all outputs 0, no `done`. With `run`=0, the block stays in T0.
